// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared defaults, entry type and pointer sizing for the retire buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

   localparam int c_WIDTH_DEF = 4;

   typedef struct packed {
      logic                   tag;
      logic [c_WIDTH_DEF-1:0] data;
   } entry_t;

   // Index bits plus one wrap bit, so full and empty stay distinguishable.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_retire_mem.sv
// ============================================================================
// Module   : pipe_retire_mem
// Brief    : DEPTH x (WIDTH+1) register array, one write port, async read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_retire_mem
   import pipe_pkg::*;
#(
   parameter int WIDTH = c_WIDTH_DEF,
   parameter int DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH:0]           wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH:0]           rdata
);

   logic [WIDTH:0] r_mem [DEPTH];

   // Storage is deliberately left unreset; validity lives in the pointers.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/pipe_retire_buf.sv
// ============================================================================
// Module   : pipe_retire_buf
// Brief    : In-order retire FIFO behind the stall pipeline, with ghost tag and
//            wrapping retire counter. Optional macro RETIRE_BYPASS_EN enables
//            a zero-latency empty-buffer bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_retire_buf
   import pipe_pkg::*;
#(
   parameter int WIDTH = c_WIDTH_DEF,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_tag,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_tag,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic [CNT_W-1:0]       retire_cnt,
   output logic                   tag_retired
);

   localparam int c_PW = ptr_w(DEPTH);
   localparam int c_AW = c_PW - 1;

   logic [c_PW-1:0]  r_wr_ptr;
   logic [c_PW-1:0]  r_rd_ptr;
   logic [CNT_W-1:0] r_retire_cnt;
   logic             r_tag_retired;

   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_pop_mem;
   logic [WIDTH:0]   w_head;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                    (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);

   assign in_ready = !w_full;

`ifdef RETIRE_BYPASS_EN
   logic w_bypass;

   // An empty buffer forwards the incoming value; it is only stored if not consumed.
   assign w_bypass  = w_empty & in_valid;
   assign out_valid = !w_empty | in_valid;
   assign out_data  = w_bypass ? in_data : w_head[WIDTH-1:0];
   assign out_tag   = w_bypass ? in_tag  : w_head[WIDTH];
   assign w_push    = in_valid & in_ready & ~(w_empty & out_ready);
`else
   assign out_valid = !w_empty;
   assign out_data  = w_head[WIDTH-1:0];
   assign out_tag   = w_head[WIDTH];
   assign w_push    = in_valid & in_ready;
`endif

   assign w_pop     = out_valid & out_ready;
   assign w_pop_mem = w_pop & !w_empty;

   pipe_retire_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (w_push),
      .waddr (r_wr_ptr[c_AW-1:0]),
      .wdata ({in_tag, in_data}),
      .raddr (r_rd_ptr[c_AW-1:0]),
      .rdata (w_head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_retire_cnt  <= '0;
         r_tag_retired <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PW'(1);
         end
         if (w_pop_mem) begin
            r_rd_ptr <= r_rd_ptr + c_PW'(1);
         end
         if (w_pop) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            if (out_tag) begin
               r_tag_retired <= 1'b1;
            end
         end
      end
   end

   assign occupancy   = r_wr_ptr - r_rd_ptr;
   assign retire_cnt  = r_retire_cnt;
   assign tag_retired = r_tag_retired;

endmodule

`default_nettype wire

// File: tb/tb_pipe_retire_buf.sv
// ============================================================================
// Module   : tb_pipe_retire_buf
// Brief    : Directed self-checking bench for pipe_retire_buf.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_retire_buf;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_tag;
   logic       in_ready;
   logic       out_valid;
   logic [3:0] out_data;
   logic       out_tag;
   logic       out_ready;
   logic [2:0] occupancy;
   logic [7:0] retire_cnt;
   logic       tag_retired;

   int n_cmp;
   int n_bad;

   pipe_retire_buf #(
      .WIDTH (4),
      .DEPTH (4),
      .CNT_W (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_tag      (in_tag),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_tag     (out_tag),
      .out_ready   (out_ready),
      .occupancy   (occupancy),
      .retire_cnt  (retire_cnt),
      .tag_retired (tag_retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] d, input logic t);
      in_valid = 1'b1;
      in_data  = d;
      in_tag   = t;
      step();
      in_valid = 1'b0;
      in_tag   = 1'b0;
   endtask

   logic [3:0] fill_vals [4];
   logic [3:0] tag_vals  [3];
   logic       tag_bits  [3];

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_tag    = 1'b0;
      out_ready = 1'b0;
      fill_vals = '{4'd1, 4'd3, 4'd7, 4'd15};
      tag_vals  = '{4'd2, 4'd5, 4'd8};
      tag_bits  = '{1'b0, 1'b1, 1'b0};

      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_retire_cnt", retire_cnt, 0);
      chk("rst_tag_retired", tag_retired, 0);
      step();
      rst_n = 1'b1;
      step();

      // No in->out combinational path in the default build.
`ifndef RETIRE_BYPASS_EN
      in_valid = 1'b1;
      in_data  = 4'd6;
      #1;
      chk("no_bypass_valid", out_valid, 0);
      in_valid = 1'b0;
      #1;
`endif

      // Fill
      for (int i = 0; i < 4; i++) begin
         push(fill_vals[i], 1'b0);
         chk("fill_occ", occupancy, i + 1);
      end
      chk("full_in_ready", in_ready, 0);
      push(4'd9, 1'b0);
      chk("full_ignore_occ", occupancy, 4);

      // Drain in order
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid", out_valid, 1);
         chk("drain_data", out_data, fill_vals[i]);
         step();
      end
      out_ready = 1'b0;
      chk("drain_empty_valid", out_valid, 0);
      chk("drain_occ", occupancy, 0);
      chk("drain_cnt", retire_cnt, 4);
      chk("drain_in_ready", in_ready, 1);

      // Ghost tag follows value 5
      for (int i = 0; i < 3; i++) push(tag_vals[i], tag_bits[i]);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("tag_head_data", out_data, tag_vals[i]);
         chk("tag_head_tag", out_tag, tag_bits[i]);
         chk("tag_retired_pre", tag_retired, (i >= 2) ? 1 : 0);
         step();
      end
      out_ready = 1'b0;
      step();
      chk("tag_retired_sticky", tag_retired, 1);
      chk("tag_cnt", retire_cnt, 7);

      // Full with simultaneous pop: the push must be refused.
      for (int i = 0; i < 4; i++) push(4'(10 + i), 1'b0);
      chk("full2_occ", occupancy, 4);
      in_valid  = 1'b1;
      in_data   = 4'd14;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("full_pop_occ", occupancy, 3);
      chk("full_pop_in_ready", in_ready, 1);
      for (int i = 1; i < 4; i++) begin
         chk("full_pop_data", out_data, 10 + i);
         step();
      end
      out_ready = 1'b0;
      chk("full_pop_empty", out_valid, 0);
      chk("full_pop_cnt", retire_cnt, 11);

      // Streaming: one push and one pop per cycle, occupancy pinned at 1.
      in_valid = 1'b1;
      for (int k = 0; k <= 20; k++) begin
         in_data   = 4'(k);
         out_ready = (k > 0);
         #1;
         if (k > 0) begin
            chk("stream_data", out_data, (k - 1) & 15);
            chk("stream_occ", occupancy, 1);
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("stream_cnt", retire_cnt, 31);
      chk("stream_occ_end", occupancy, 1);

      // Async reset mid-burst at occupancy 2
      push(4'd4, 1'b0);
      chk("pre_rst_occ", occupancy, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_occ", occupancy, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_cnt", retire_cnt, 0);
      chk("arst_tag", tag_retired, 0);
      step();
      rst_n = 1'b1;
      step();

      // Retire counter wrap after 257 pops
      in_valid = 1'b1;
      for (int k = 0; k <= 257; k++) begin
         in_data   = 4'(k);
         out_ready = (k > 0);
         #1;
         if (k == 256) chk("cnt_pre_wrap", retire_cnt, 255);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("cnt_wrap", retire_cnt, 1);
      step();
      out_ready = 1'b0;
      chk("cnt_wrap_empty", out_valid, 0);

`ifdef RETIRE_BYPASS_EN
      // Empty buffer passes the value through in the same cycle.
      in_valid  = 1'b1;
      in_data   = 4'd6;
      out_ready = 1'b1;
      #1;
      chk("byp_valid", out_valid, 1);
      chk("byp_data", out_data, 6);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("byp_occ", occupancy, 0);
      chk("byp_cnt", retire_cnt, 3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_retire_buf.md
Name: pipe_retire_buf

Overview:
- Downstream neighbour of the 3-stage stall pipeline: consumes the stage-3 result and buffers it in an in-order FIFO until a consumer retires it.
- Back-pressure is driven through in_ready, which the integrator ties to the pipeline's stage-3 stall input (stall3in = !in_ready).
- Carries one ghost tag bit per entry so formal properties can follow a marked value from pipeline to retirement.
- Maintains a wrapping retire counter.

Parameters:
- WIDTH, 4, data width; matches the pipeline datapath.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 8, retire counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has a result (pipeline stage-3 go).
- in_data  input  WIDTH  result value.
- in_tag  input  1  ghost tag of the incoming value.
- in_ready  output  1  buffer can accept; drives stall3in = !in_ready.
- out_valid  output  1  head entry available.
- out_data  output  WIDTH  head value.
- out_tag  output  1  ghost tag of the head entry.
- out_ready  input  1  consumer retires the head this cycle.
- occupancy  output  clog2(DEPTH)+1  current entry count.
- retire_cnt  output  CNT_W  number of pops, wraps modulo 2^CNT_W.
- tag_retired  output  1  sticky; set when a tagged entry pops.

Behaviour:
- Reset: the async assert of rst_n clears the following state.
  - Pointers, occupancy, retire_cnt and tag_retired go to 0.
  - out_valid goes to 0 and in_ready goes to 1.
  - Storage contents are not reset. out_data is don't-care while out_valid is 0.
  - Reset release is synchronous to clk.
- Pointers: wr_ptr and rd_ptr are clog2(DEPTH)+1 bits wide, with the MSB as the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (index bits equal) && (wrap bits differ).
- Handshake:
  - in_ready = !full. This is purely registered-state derived; there is no combinational path from out_ready.
  - push = in_valid & in_ready.
  - out_valid = !empty.
  - pop = out_valid & out_ready.
- Push: writes {in_tag, in_data} at wr_ptr, then wr_ptr increments.
- Pop: rd_ptr increments and retire_cnt increments.
  - If out_tag is 1 on the pop, tag_retired sets and stays set until reset.
- Latency: a push is visible at out_valid/out_data on the next cycle (1-cycle minimum), in strict FIFO order.
- Simultaneous events:
  - Push and pop together when 0 < occupancy < DEPTH: occupancy is unchanged and both pointers advance.
  - Full: no push, even if pop occurs that cycle; in_ready rises the cycle after the pop.
  - Empty: no pop. A push still lands and out_valid rises the next cycle.
- Overflow/underflow: impossible by construction.
  - in_valid while !in_ready is ignored; the upstream stalls and holds the value.
  - out_ready while !out_valid is ignored.
- Wrap-around: pointer index wraps DEPTH-1 -> 0 with the wrap bit toggled. retire_cnt wraps 2^CNT_W-1 -> 0.
- occupancy = wr_ptr - rd_ptr, modulo pointer width.
- Reset mid-operation: all in-flight entries are discarded. The upstream must also be reset.

Optional Feature:
- Macro: RETIRE_BYPASS_EN.
- Defined:
  - When empty && in_valid && out_ready, the value passes combinationally to out_data/out_tag, with out_valid=1.
  - No write occurs and pointers are unchanged. retire_cnt and tag_retired still update.
  - out_valid = !empty || in_valid.
  - Latency is 0 cycles for that case.
- Undefined: no bypass, strict 1-cycle minimum latency, and no in->out combinational path.

Decomposition:
- Shared package pipe_pkg holds:
  - the WIDTH default;
  - an entry typedef {tag, data};
  - a pointer-width function (clog2(DEPTH)+1).
- One sub-module, pipe_retire_mem: a DEPTH x (WIDTH+1) register array with one write port and one async read port.
- Control, pointers and counters stay in pipe_retire_buf.

Test Plan:
- Fill: out_ready=0, push 1,3,7,15 -> in_ready=0 after the 4th push, occupancy=4; a 5th in_valid with data 9 is not accepted.
- Drain: from full, out_ready=1 for 4 cycles -> out_data 1,3,7,15 in order, retire_cnt=4, occupancy=0, out_valid=0 in cycle 5.
- Streaming: in_valid=1 and out_ready=1 continuously after the first push -> occupancy stays at 1 and one pop per cycle; retire_cnt=20 after 20 pops. Covers pointer wrap 3->0 (wrap bit toggles).
- Full with simultaneous pop: at occupancy=4 assert in_valid and out_ready -> no push that cycle, occupancy=3; in_ready=1 the next cycle.
- Ghost tag: push data 5 with in_tag=1 among untagged values -> out_tag=1 exactly when out_data=5 is at the head; tag_retired=1 the cycle after its pop and sticky thereafter.
- Async reset: drop rst_n mid-burst at occupancy=2 -> out_valid=0, occupancy=0, in_ready=1 immediately, without waiting for a clock edge.
- RETIRE_BYPASS_EN: empty, in_valid=1, in_data=6, out_ready=1 -> out_data=6 same cycle, occupancy remains 0, retire_cnt increments.
